// File: rtl/leb128_pkg.sv
// Shared definitions for the LEB128 immediate decoder: operand type codes,
// trap codes and the decoder state encoding.
package leb128_pkg;

    localparam logic [1:0] TYPE_I32    = 2'd1;
    localparam logic [1:0] TYPE_I64    = 2'd2;

    localparam logic [2:0] TRAP_NONE   = 3'd0;
    localparam logic [2:0] INVALID_LEB = 3'd1;

    typedef enum logic [1:0] {
        LEB_IDLE  = 2'd0,
        LEB_ACCUM = 2'd1,
        LEB_DONE  = 2'd2,
        LEB_ERROR = 2'd3
    } leb_state_t;

    function automatic logic [1:0] result_type(input logic is_64);
        return is_64 ? TYPE_I64 : TYPE_I32;
    endfunction

endpackage

// File: rtl/leb128_finalize.sv
// Merges one LEB128 byte into the accumulator, extends the result and checks its range.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the outputs are used.
module leb128_finalize
    import leb128_pkg::*;
#(
    parameter int MAX_BYTES_64 = 10,
    parameter int MAX_BYTES_32 = 5
) (
    input  logic [63:0] acc,
    input  logic [3:0]  count,
    input  logic [7:0]  data,
    input  logic        is_signed,
    input  logic        is_64,
    output logic [63:0] merged,
    output logic [63:0] value,
    output logic        err
);

    logic [6:0] shift;
    logic [6:0] width;
    logic [3:0] last_idx;
    logic       range_bad;

    always_comb begin
        // count never exceeds 9, so the shift tops out at bit 63 and higher bits fall off
        shift  = 7'(count) * 7'd7;
        width  = shift + 7'd7;
        merged = acc | ({57'd0, data[6:0]} << shift);

        value = merged;
        if (is_signed && data[6] && (width < 7'd64)) begin
            value = value | ({64{1'b1}} << width);
        end
        if (!is_64) begin
            value = is_signed ? {{32{value[31]}}, value[31:0]} : {32'd0, value[31:0]};
        end

        last_idx  = is_64 ? 4'(MAX_BYTES_64 - 1) : 4'(MAX_BYTES_32 - 1);
        range_bad = 1'b0;
        case ({is_64, is_signed})
            2'b11:   range_bad = !((data[6:0] == 7'h00) || (data[6:0] == 7'h7f));
            2'b10:   range_bad = (data[6:1] != 6'd0);
            2'b01:   range_bad = !((data[6:3] == 4'h0) || (data[6:3] == 4'hf));
            default: range_bad = (data[6:4] != 3'd0);
        endcase
        err = (count == last_idx) && (data[7] || range_bad);
    end

endmodule

// File: rtl/leb128_decoder.sv
// Byte-serial LEB128 immediate decoder producing a 64-bit typed operand or an INVALID_LEB trap.
// Latency: out_valid rises the cycle after the final byte is accepted; one value per (bytes+1) cycles.
// Backpressure: holds the result while out_ready=0 with in_ready=0; a trap freezes the block until reset.
module leb128_decoder
    import leb128_pkg::*;
#(
    parameter int MAX_BYTES_64 = 10,
    parameter int MAX_BYTES_32 = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    input  logic        is_signed,
    input  logic        is_64,
    output logic        out_valid,
    output logic [63:0] out_value,
    output logic [1:0]  out_type,
    input  logic        out_ready,
    output logic [2:0]  trap
);

    leb_state_t  state;
    logic [63:0] acc;
    logic [3:0]  count;
    logic        sgn_q;
    logic        w64_q;

    logic        first;
    logic [63:0] fin_acc;
    logic [3:0]  fin_count;
    logic        fin_signed;
    logic        fin_64;
    logic [63:0] fin_merged;
    logic [63:0] fin_value;
    logic        fin_err;
    logic        in_xfer;

    // The first byte takes its mode straight from the inputs; later bytes use the latched mode.
    assign first      = (state == LEB_IDLE);
    assign fin_acc    = first ? 64'd0 : acc;
    assign fin_count  = first ? 4'd0 : count;
    assign fin_signed = first ? is_signed : sgn_q;
    assign fin_64     = first ? is_64 : w64_q;
    assign in_xfer    = in_valid && in_ready;

    leb128_finalize #(
        .MAX_BYTES_64 (MAX_BYTES_64),
        .MAX_BYTES_32 (MAX_BYTES_32)
    ) u_finalize (
        .acc       (fin_acc),
        .count     (fin_count),
        .data      (in_byte),
        .is_signed (fin_signed),
        .is_64     (fin_64),
        .merged    (fin_merged),
        .value     (fin_value),
        .err       (fin_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LEB_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_value <= 64'd0;
            out_type  <= 2'd0;
            trap      <= TRAP_NONE;
            acc       <= 64'd0;
            count     <= 4'd0;
            sgn_q     <= 1'b0;
            w64_q     <= 1'b0;
        end else begin
            case (state)
                LEB_IDLE, LEB_ACCUM: begin
                    in_ready <= 1'b1;
                    if (in_xfer) begin
                        acc   <= fin_merged;
                        count <= fin_count + 4'd1;
                        sgn_q <= fin_signed;
                        w64_q <= fin_64;
                        if (fin_err) begin
                            state    <= LEB_ERROR;
                            in_ready <= 1'b0;
                            trap     <= INVALID_LEB;
                        end else if (!in_byte[7]) begin
                            state     <= LEB_DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_value <= fin_value;
                            out_type  <= result_type(fin_64);
                        end else begin
                            state <= LEB_ACCUM;
                        end
                    end
                end
                LEB_DONE: begin
                    in_ready <= 1'b0;
                    if (out_ready) begin
                        state     <= LEB_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        acc       <= 64'd0;
                        count     <= 4'd0;
                    end
                end
                default: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    trap      <= INVALID_LEB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leb128_decoder.sv
// Directed bench for leb128_decoder: hand-computed vectors, backpressure, traps and async reset.
module tb_leb128_decoder;
    import leb128_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'd0;
    logic        in_ready;
    logic        is_signed = 1'b0;
    logic        is_64 = 1'b0;
    logic        out_valid;
    logic [63:0] out_value;
    logic [1:0]  out_type;
    logic        out_ready = 1'b0;
    logic [2:0]  trap;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    leb128_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .is_signed (is_signed),
        .is_64     (is_64),
        .out_valid (out_valid),
        .out_value (out_value),
        .out_type  (out_type),
        .out_ready (out_ready),
        .trap      (trap)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the byte was taken.
    task automatic push(input logic [7:0] b, input logic s, input logic w);
        int n = 0;
        in_valid  = 1'b1;
        in_byte   = b;
        is_signed = s;
        is_64     = w;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("push_timeout", 64'd0, 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic take(input string tag, input logic [63:0] exp_val, input logic [1:0] exp_type);
        chk({tag, "_vld"}, 64'(out_valid), 64'd1);
        chk({tag, "_val"}, out_value, exp_val);
        chk({tag, "_type"}, 64'(out_type), 64'(exp_type));
        chk({tag, "_trap"}, 64'(trap), 64'(TRAP_NONE));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_vld_clr"}, 64'(out_valid), 64'd0);
        chk({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_trap(input string tag);
        chk({tag, "_trap"}, 64'(trap), 64'(INVALID_LEB));
        chk({tag, "_vld"}, 64'(out_valid), 64'd0);
        chk({tag, "_rdy"}, 64'(in_ready), 64'd0);
    endtask

    logic [7:0] u32_a [3] = '{8'he5, 8'h8e, 8'h26};
    logic [7:0] s32_b [5] = '{8'hff, 8'hff, 8'hff, 8'hff, 8'h07};
    logic [63:0] held;

    initial begin
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_value", out_value, 64'd0);
        chk("rst_out_type", 64'(out_type), 64'd0);
        chk("rst_trap", 64'(trap), 64'd0);
        apply_reset();
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // Signed 64: 80 x8 then 40
        for (int i = 0; i < 8; i++) push(8'h80, 1'b1, 1'b1);
        chk("s64_pre_vld", 64'(out_valid), 64'd0);
        push(8'h40, 1'b1, 1'b1);
        take("s64_c0", 64'hc000000000000000, TYPE_I64);

        push(8'h7e, 1'b1, 1'b1);
        take("s64_7e", 64'hfffffffffffffffe, TYPE_I64);

        for (int i = 0; i < 3; i++) push(u32_a[i], 1'b0, 1'b0);
        take("u32_98765", 64'h0000000000098765, TYPE_I32);

        // Backpressure, with a new byte waiting upstream during DONE
        push(8'h7e, 1'b1, 1'b1);
        held      = out_value;
        in_valid  = 1'b1;
        in_byte   = 8'h05;
        is_signed = 1'b0;
        is_64     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_vld", 64'(out_valid), 64'd1);
            chk("bp_val", out_value, 64'hfffffffffffffffe);
            chk("bp_rdy", 64'(in_ready), 64'd0);
        end
        take("bp_take", held, TYPE_I64);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        take("bp_next", 64'd5, TYPE_I32);

        for (int i = 0; i < 5; i++) push(s32_b[i], 1'b1, 1'b0);
        take("s32_max", 64'h000000007fffffff, TYPE_I32);

        for (int i = 0; i < 4; i++) push(8'h80, 1'b1, 1'b0);
        push(8'h78, 1'b1, 1'b0);
        take("s32_min", 64'hffffffff80000000, TYPE_I32);

        for (int i = 0; i < 4; i++) push(8'h80, 1'b0, 1'b0);
        push(8'h10, 1'b0, 1'b0);
        expect_trap("u32_range");
        repeat (3) @(negedge clk);
        chk("u32_sticky", 64'(trap), 64'(INVALID_LEB));
        apply_reset();

        for (int i = 0; i < 9; i++) push(8'h80, 1'b1, 1'b1);
        chk("s64_long_pre", 64'(trap), 64'd0);
        push(8'h80, 1'b1, 1'b1);
        expect_trap("s64_long");
        apply_reset();

        for (int i = 0; i < 4; i++) push(8'h80, 1'b1, 1'b0);
        push(8'h08, 1'b1, 1'b0);
        expect_trap("s32_range");
        apply_reset();

        // Async reset mid-decode with a stale output value present
        push(8'h7e, 1'b1, 1'b1);
        take("pre_rst", 64'hfffffffffffffffe, TYPE_I64);
        for (int i = 0; i < 3; i++) push(8'h80, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_value", out_value, 64'd0);
        chk("arst_trap", 64'(trap), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        push(8'h01, 1'b0, 1'b1);
        take("post_rst", 64'h1, TYPE_I64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/leb128_decoder.md
Name: leb128_decoder

Overview:
- Byte-serial LEB128 immediate decoder between the ROM byte fetch and the cpu execute stage.
- Turns the unsigned/signed LEB128 immediates in the bytecode (i32.const, i64.const, indices, offsets) into a 64-bit operand tagged with its result type.
- Flags malformed encodings as a trap.
- Consumes one ROM byte per cycle; hands one decoded value to the stack-push logic via valid/ready.

Parameters:
- MAX_BYTES_64, 10, byte limit for 64-bit encodings
- MAX_BYTES_32, 5, byte limit for 32-bit encodings

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (block in reset while 0)
- in_valid  in  1  in_byte valid
- in_byte  in  8  LEB128 byte from ROM fetch
- in_ready  out  1  decoder accepts in_byte this cycle
- is_signed  in  1  signed (sLEB) decode; sampled with first byte only
- is_64  in  1  64-bit target, else 32-bit; sampled with first byte only
- out_valid  out  1  decoded value available
- out_value  out  64  decoded value, sign/zero-extended to 64 bits
- out_type  out  2  `i32 or `i64 (cpu.vh encoding)
- out_ready  in  1  consumer takes value
- trap  out  3  0 = none, `INVALID_LEB on malformed encoding

Behaviour:
- Reset values: in_ready=0 while reset low, 1 in IDLE after release; out_valid=0; out_value=0; out_type=0; trap=0. Accumulator, byte count and mode flags are cleared.
- Reset mid-decode: partial value is discarded. An already-presented output is dropped.
- Byte transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- States:
  - IDLE: in_ready=1. A transfer latches is_signed/is_64, places byte[6:0] at bits 6:0, and sets count=1. If byte[7]=0, go to DONE; else go to ACCUM.
  - ACCUM: in_ready=1. Each transfer ORs byte[6:0] into bits [7*count +: 7], clipped at bit 63, and increments count. byte[7]=0 goes to DONE.
  - DONE: in_ready=0. out_valid=1; out_value and out_type are stable until the output transfer. On transfer, go to IDLE with out_valid=0 the next cycle.
  - ERROR: in_ready=0, out_valid=0, trap=`INVALID_LEB. Held until reset; trap is sticky.
- Latency: final byte accepted in cycle N, so out_valid=1 in cycle N+1. Back-to-back throughput is one value per (bytes+1) cycles. No byte is accepted in the DONE cycle.
- Finalisation happens in the cycle the final byte is accepted:
  - Signed, and final byte[6]=1, and 7*count < width: fill bits [63:7*count] with 1.
  - Otherwise zero-extend above bit 7*count.
  - 32-bit results are then extended from bit 31 (signed) or zeroed above bit 31 (unsigned).
  - out_type=`i64 if is_64, else `i32.
- Error checks, on the byte at index L-1, where L=MAX_BYTES_64 or MAX_BYTES_32:
  - Too long: byte[7]=1 goes to ERROR.
  - 64-bit unsigned: byte[6:1] must be 0.
  - 64-bit signed: byte[6:0] must be 7'h00 or 7'h7f.
  - 32-bit unsigned: byte[6:4] must be 0.
  - 32-bit signed: byte[6:3] must be all-0 or all-1.
  - Any violation goes to ERROR instead of DONE.
- Mode changes on is_signed/is_64 after the first byte are ignored until the next IDLE.
- Simultaneous in_valid during DONE: the byte is not consumed (in_ready=0). The upstream stage holds it.

Decomposition:
- cpu.vh holds the shared definitions:
  - `i32/`i64 type codes, already shared.
  - New trap code `INVALID_LEB.
  - State encodings LEB_IDLE/LEB_ACCUM/LEB_DONE/LEB_ERROR.
- Optional sub-module leb128_finalize: combinational extension and range checks given accumulator, count, last byte and mode. This keeps the FSM file small and is separately unit-testable.
- No other sub-modules.

Test Plan:
- Signed 64, bytes 80 80 80 80 80 80 80 80 40 -> out_value=64'hc000000000000000, out_type=`i64, trap=0, out_valid rises one cycle after byte 9.
- Signed 64, single byte 7E -> out_value=64'hfffffffffffffffe. Unsigned 32, bytes E5 8E 26 -> out_value=64'h0000000000098765, out_type=`i32.
- Backpressure: decode 7E with out_ready=0 for 5 cycles -> out_valid and out_value held constant, in_ready=0 throughout; out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- Malformed inputs:
  - Unsigned 32, bytes 80 80 80 80 10 -> trap=`INVALID_LEB, out_valid never asserted.
  - Signed 64, ten bytes of 80 -> trap on byte 10, in_ready=0 after.
- Boundary:
  - Signed 32, bytes FF FF FF FF 07 -> 64'h000000007fffffff.
  - Bytes 80 80 80 80 78 -> 64'hffffffff80000000.
  - Byte 08 as the 5th signed-32 byte -> trap.
- Reset low asynchronously after 3 of 5 bytes -> all outputs 0 immediately. After release, byte 01 decodes to 64'h1 with no residue.
